snitch_shared_muldiv_arb: RTL

Round-robin arbiter that shares one cluster-level shared multiply/divide unit (accelerator address `SHARED_MULDIV`) among `NrCores` Snitch cores. It sits between the per-core accelerator offload ports and the single muldiv unit. Responses are routed back to the issuing core through an in-order tag FIFO. Grants are locked while a request is stalled, so the request stays stable toward the unit.

---
 rtl/snitch_shared_muldiv_arb.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/snitch_shared_muldiv_arb.sv
// Round-robin arbiter sharing one muldiv unit among NrCores cores; responses return via an in-order tag FIFO.
// Optional contention counter enabled by defining SNITCH_MULDIV_ARB_PERF_EN.
module snitch_shared_muldiv_arb #(
  parameter int unsigned NrCores        = 4,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned IdWidth        = 5,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NrCores-1:0]                  core_q_valid_i,
  output logic [NrCores-1:0]                  core_q_ready_o,
  input  logic [NrCores-1:0][31:0]            core_q_op_i,
  input  logic [NrCores-1:0][DataWidth-1:0]   core_q_arga_i,
  input  logic [NrCores-1:0][DataWidth-1:0]   core_q_argb_i,
  input  logic [NrCores-1:0][IdWidth-1:0]     core_q_id_i,
  output logic [NrCores-1:0]                  core_p_valid_o,
  input  logic [NrCores-1:0]                  core_p_ready_i,
  output logic [DataWidth-1:0]                core_p_data_o,
  output logic [IdWidth-1:0]                  core_p_id_o,
  output logic                                core_p_error_o,
  output logic                                mu_q_valid_o,
  input  logic                                mu_q_ready_i,
  output logic [31:0]                         mu_q_op_o,
  output logic [DataWidth-1:0]                mu_q_arga_o,
  output logic [DataWidth-1:0]                mu_q_argb_o,
  output logic [IdWidth-1:0]                  mu_q_id_o,
  input  logic                                mu_p_valid_i,
  output logic                                mu_p_ready_o,
  input  logic [DataWidth-1:0]                mu_p_data_i,
  input  logic [IdWidth-1:0]                  mu_p_id_i,
  input  logic                                mu_p_error_i,
  output logic [31:0]                         contention_cnt_o
);

  localparam int unsigned IdxW = $clog2(NrCores);
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding) + 1;

  logic [IdxW-1:0] rr_q, lock_idx_q, grant, head;
  logic            lock_q, lock_d;
  logic [IdxW-1:0] fifo_q [MaxOutstanding];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] occ_q;
  logic            full, empty, push, pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Reverse scan so the valid core closest to rr_q is written last and wins.
  always_comb begin
    int unsigned idx;
    idx   = 0;
    grant = rr_q;
    if (lock_q) begin
      grant = lock_idx_q;
    end else begin
      for (int i = NrCores - 1; i >= 0; i--) begin
        idx = (int'(rr_q) + i) % NrCores;
        if (core_q_valid_i[idx]) grant = IdxW'(idx);
      end
    end
  end

  assign full  = (occ_q == CntW'(MaxOutstanding));
  assign empty = (occ_q == '0);

  assign mu_q_valid_o = core_q_valid_i[grant] & ~full;
  assign mu_q_op_o    = core_q_op_i[grant];
  assign mu_q_arga_o  = core_q_arga_i[grant];
  assign mu_q_argb_o  = core_q_argb_i[grant];
  assign mu_q_id_o    = core_q_id_i[grant];
  assign push         = mu_q_valid_o & mu_q_ready_i;
  // Any stalled offer re-locks; a handshake or a dropped valid releases the lock.
  assign lock_d       = mu_q_valid_o & ~mu_q_ready_i;

  always_comb begin
    core_q_ready_o        = '0;
    core_q_ready_o[grant] = mu_q_ready_i & ~full;
  end

  assign head           = fifo_q[rd_ptr_q];
  assign mu_p_ready_o   = core_p_ready_i[head] & ~empty;
  assign pop            = mu_p_valid_i & mu_p_ready_o;
  assign core_p_data_o  = mu_p_data_i;
  assign core_p_id_o    = mu_p_id_i;
  assign core_p_error_o = mu_p_error_i;

  always_comb begin
    core_p_valid_o       = '0;
    core_p_valid_o[head] = mu_p_valid_i & ~empty;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
    end else begin
      lock_q <= lock_d;
      if (lock_d) lock_idx_q <= grant;
      if (push) begin
        rr_q     <= (grant == IdxW'(NrCores - 1)) ? '0 : grant + IdxW'(1);
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   occ_q <= occ_q + CntW'(1);
        2'b01:   occ_q <= occ_q - CntW'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  // Tag storage carries no reset; occupancy alone defines which entries are live.
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= grant;
  end

`ifdef SNITCH_MULDIV_ARB_PERF_EN
  logic [31:0] cnt_q;
  logic        multi_valid;

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign multi_valid = |(core_q_valid_i & (core_q_valid_i - NrCores'(1)));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (multi_valid && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign contention_cnt_o = cnt_q;
`else
  assign contention_cnt_o = '0;
`endif

`ifndef SYNTHESIS
  assert property (@(posedge clk_i) disable iff (rst_i) !(mu_p_valid_i && empty))
    else $error("response from muldiv unit with no outstanding tag");
  assert property (@(posedge clk_i) disable iff (rst_i) lock_q |-> core_q_valid_i[lock_idx_q])
    else $error("core dropped valid while its request was locked");
`endif

endmodule
